// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry output/skid buffer.
// Optional RVC decode of 16-bit words is built when RVC_IMM_EN is defined.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    TypeNone, TypeI, TypeS, TypeB, TypeU, TypeJ, TypeZimm, TypeShamt
  } imm_type_e;

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  state_e state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  imm_type_e       base_type, dec_type;
  logic [XLEN-1:0] base_imm, dec_imm;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21],
                                1'b0}));

  always_comb begin
    base_type = TypeNone;
    base_imm  = '0;
    case (opcode)
      7'b0000011, 7'b1100111: begin base_type = TypeI; base_imm = imm_i; end
      7'b0010011: begin
        // Shift forms take only the shamt field so funct7 never reaches the result
        if (is_shift) begin
          base_type = TypeShamt;
          base_imm  = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
        end else begin
          base_type = TypeI;
          base_imm  = imm_i;
        end
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            base_type = TypeShamt;
            base_imm  = XLEN'(in_instr[24:20]);
          end else begin
            base_type = TypeI;
            base_imm  = imm_i;
          end
        end
      end
      7'b0100011:             begin base_type = TypeS; base_imm = imm_s; end
      7'b1100011:             begin base_type = TypeB; base_imm = imm_b; end
      7'b0110111, 7'b0010111: begin base_type = TypeU; base_imm = imm_u; end
      7'b1101111:             begin base_type = TypeJ; base_imm = imm_j; end
      7'b1110011: begin
        if (funct3[2]) begin
          base_type = TypeZimm;
          base_imm  = XLEN'(in_instr[19:15]);
        end
      end
      default: ;
    endcase
  end

`ifdef RVC_IMM_EN
  logic [15:0]     c;
  logic [XLEN-1:0] c_imm6, c_shamt, c_lsw;
  imm_type_e       rvc_type;
  logic [XLEN-1:0] rvc_imm;

  assign c       = in_instr[15:0];
  assign c_imm6  = XLEN'($signed({c[12], c[6:2]}));
  assign c_shamt = (XLEN == 64) ? XLEN'({c[12], c[6:2]}) : XLEN'(c[6:2]);
  assign c_lsw   = XLEN'({c[5], c[12:10], c[6], 2'b00});

  always_comb begin
    rvc_type = TypeNone;
    rvc_imm  = '0;
    case ({c[1:0], c[15:13]})
      5'b00_010:            begin rvc_type = TypeI; rvc_imm = c_lsw;  end
      5'b00_110:            begin rvc_type = TypeS; rvc_imm = c_lsw;  end
      5'b01_000, 5'b01_010: begin rvc_type = TypeI; rvc_imm = c_imm6; end
      5'b01_001, 5'b01_101: begin
        // Funct3 001 is C.JAL only on RV32; on RV64 it is C.ADDIW
        if ((c[15:13] == 3'b101) || (XLEN == 32)) begin
          rvc_type = TypeJ;
          rvc_imm  = XLEN'($signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3],
                                    1'b0}));
        end
      end
      5'b01_011: begin
        if ((c[11:7] != 5'd0) && (c[11:7] != 5'd2)) begin
          rvc_type = TypeU;
          rvc_imm  = XLEN'($signed({c[12], c[6:2], 12'b0}));
        end
      end
      5'b01_100: begin
        if (!c[11]) begin rvc_type = TypeShamt; rvc_imm = c_shamt; end
      end
      5'b01_110, 5'b01_111: begin
        rvc_type = TypeB;
        rvc_imm  = XLEN'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
      end
      5'b10_000: begin rvc_type = TypeShamt; rvc_imm = c_shamt; end
      default: ;
    endcase
  end

  assign dec_type = (in_instr[1:0] != 2'b11) ? rvc_type : base_type;
  assign dec_imm  = (in_instr[1:0] != 2'b11) ? rvc_imm : base_imm;
`else
  assign dec_type = base_type;
  assign dec_imm  = base_imm;
`endif

  logic            accept, load_out, load_from_skid, load_skid;
  logic [XLEN-1:0] out_imm_q, skid_imm_q;
  imm_type_e       out_type_q, skid_type_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d        = state_q;
    load_out       = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: if (accept) begin state_d = StBusy; load_out = 1'b1; end
        StBusy: begin
          if (out_ready) begin
            if (accept) load_out = 1'b1;
            else        state_d = StEmpty;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = StFull;
          end
        end
        StFull: if (out_ready) begin state_d = StBusy; load_from_skid = 1'b1; end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      out_imm_q   <= '0;
      out_type_q  <= TypeNone;
      out_tag_q   <= '0;
      skid_imm_q  <= '0;
      skid_type_q <= TypeNone;
      skid_tag_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_out) begin
        out_imm_q  <= dec_imm;
        out_type_q <= dec_type;
        out_tag_q  <= in_tag;
      end else if (load_from_skid) begin
        out_imm_q  <= skid_imm_q;
        out_type_q <= skid_type_q;
        out_tag_q  <= skid_tag_q;
      end
      if (load_skid) begin
        skid_imm_q  <= dec_imm;
        skid_type_q <= dec_type;
        skid_tag_q  <= in_tag;
      end
    end
  end

  assign out_imm  = out_imm_q;
  assign out_type = out_type_q;
  assign out_tag  = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed cases then random traffic against a scoreboard model.
module tb_imm_gen_pipe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_type(out_type),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [2:0]       t;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t exp_q[$];

  logic [6:0] ops [0:11] = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h73, 7'h1B, 7'h33, 7'h13};

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference: immediates assembled arithmetically from the instruction fields
  function automatic res_t model(input logic [31:0] w, input logic [TAG_W-1:0] tag);
    res_t r;
    longint s, hi;
    longint unsigned imm;
    int unsigned op, f3;
    logic [2:0] t;
    s   = longint'($signed(w));
    op  = w & 32'h7F;
    f3  = (w >> 12) & 7;
    t   = 3'd0;
    imm = 0;
    case (op)
      'h03, 'h67: begin t = 3'd1; imm = s >>> 20; end
      'h13: begin
        if (f3 == 1 || f3 == 5) begin t = 3'd7; imm = (w >> 20) & ((XLEN == 64) ? 63 : 31); end
        else begin t = 3'd1; imm = s >>> 20; end
      end
      'h1B: begin
        if (XLEN == 64) begin
          if (f3 == 1 || f3 == 5) begin t = 3'd7; imm = (w >> 20) & 31; end
          else begin t = 3'd1; imm = s >>> 20; end
        end
      end
      'h23: begin t = 3'd2; hi = s >>> 25; imm = hi * 32 + ((w >> 7) & 31); end
      'h63: begin
        t = 3'd3; hi = s >>> 31;
        imm = hi * 4096 + ((w >> 7) & 1) * 2048 + ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2;
      end
      'h37, 'h17: begin t = 3'd4; imm = s & ~longint'(4095); end
      'h6F: begin
        t = 3'd5; hi = s >>> 31;
        imm = hi * 1048576 + ((w >> 12) & 255) * 4096 + ((w >> 20) & 1) * 2048
            + ((w >> 21) & 1023) * 2;
      end
      'h73: if (f3 >= 4) begin t = 3'd6; imm = (w >> 15) & 31; end
      default: ;
    endcase
`ifdef RVC_IMM_EN
    // Only C.ADDI/C.LI are modelled; random traffic sends no compressed words
    if ((w & 3) != 3) begin
      t = 3'd0; imm = 0;
      if ((w & 3) == 1 && (((w >> 13) & 7) == 0 || ((w >> 13) & 7) == 2)) begin
        hi = (w >> 2) & 31;
        if (((w >> 12) & 1) == 1) hi = hi - 32;
        t = 3'd1; imm = hi;
      end
    end
`endif
    r.t   = t;
    r.imm = imm[XLEN-1:0];
    r.tag = tag;
    return r;
  endfunction

  task automatic step(input logic iv, input logic [31:0] w, input logic [TAG_W-1:0] tg,
                      input logic ordy, input logic fl);
    res_t e;
    in_valid  = iv;
    in_instr  = w;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_q.size() < 2});
    if (fl) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_imm", 64'(out_imm), 64'(e.imm));
        chk("out_type", 64'(out_type), 64'(e.t));
        chk("out_tag", 64'(out_tag), 64'(e.tag));
      end
      if (in_valid && in_ready) exp_q.push_back(model(w, tg));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [63:0] imm, input logic [2:0] t);
    chk({name, "_imm"}, 64'(out_imm), imm);
    chk({name, "_type"}, 64'(out_type), 64'(t));
  endtask

  initial begin
    logic [31:0] rw, w;
    int unsigned idx;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_type", 64'(out_type), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;

    step(1'b1, 32'hFFF00093, 4'd1, 1'b1, 1'b0);
    expect_out("addi", 64'hFFFF_FFFF, 3'd1);
    step(1'b1, 32'h12345037, 4'd2, 1'b1, 1'b0);
    expect_out("lui", 64'h1234_5000, 3'd4);
    step(1'b1, 32'h0080006F, 4'd3, 1'b1, 1'b0);
    expect_out("jal", 64'd8, 3'd5);
    step(1'b1, 32'h4030D093, 4'd4, 1'b1, 1'b0);
    expect_out("srai", 64'd3, 3'd7);
    step(1'b1, 32'h0052D0F3, 4'd5, 1'b1, 1'b0);
    expect_out("csrrwi", 64'd5, 3'd6);
    step(1'b1, 32'h0050D0F3, 4'd6, 1'b1, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

    // Backpressure: two words fit, third is refused and the head holds
    step(1'b1, 32'h00500093, 4'd7, 1'b0, 1'b0);
    step(1'b1, 32'hFFC00093, 4'd8, 1'b0, 1'b0);
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 32'h00100093, 4'd9, 1'b0, 1'b0);
    expect_out("hold", 64'd5, 3'd1);
    chk("hold_tag", 64'(out_tag), 64'd7);
    repeat (3) step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

    step(1'b1, 32'h00A00093, 4'd10, 1'b0, 1'b0);
    step(1'b1, 32'h00B00093, 4'd11, 1'b0, 1'b0);
    step(1'b1, 32'h00C00093, 4'd12, 1'b0, 1'b1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    step(1'b1, 32'h00D00093, 4'd13, 1'b0, 1'b0);
    step(1'b1, 32'h00E00093, 4'd14, 1'b1, 1'b1);
    chk("flush2_out_valid", {63'd0, out_valid}, 64'd0);

    step(1'b1, 32'h12345037, 4'd15, 1'b0, 1'b0);
    step(1'b1, 32'h0080006F, 4'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_out_imm", 64'(out_imm), 64'd0);
    chk("arst_out_type", 64'(out_type), 64'd0);
    chk("arst_out_tag", 64'(out_tag), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, 32'h000050FD, 4'd2, 1'b1, 1'b0);
`ifdef RVC_IMM_EN
    expect_out("c_li", 64'hFFFF_FFFF, 3'd1);
`else
    expect_out("c_li", 64'd0, 3'd0);
`endif
    step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      rw  = $urandom;
      idx = $urandom_range(0, 11);
      w   = $urandom;
      if (idx != 11) w[6:0] = ops[idx];
`ifdef RVC_IMM_EN
      w[1:0] = 2'b11;
`endif
      step(rw[0] | rw[1], w, rw[13:10], rw[2] | rw[3], rw[9:4] == 6'd0);
    end

    for (int k = 0; k < 4; k++) step(1'b0, 32'd0, 4'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
